// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID PWM actuator.
package pid_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // PWM period in ticks for a given duty word width.
  function automatic int unsigned pwm_period(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pid_pwm_slew.sv
// Combinational slew limiter: moves d toward t by at most step (step=0 jumps to t).
module pid_pwm_slew
  import pid_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH:0]   step,
  output logic [WIDTH-1:0] slew_c
);

  localparam int unsigned EW = WIDTH + 1;

  logic [WIDTH:0] d_x;
  logic [WIDTH:0] t_x;
  logic [WIDTH:0] gap;
  logic [WIDTH:0] move;
  logic [WIDTH:0] res;

  // One extra bit keeps the step arithmetic from wrapping; result never passes t.
  always_comb begin
    d_x  = EW'(d);
    t_x  = EW'(t);
    gap  = (t_x > d_x) ? (t_x - d_x) : (d_x - t_x);
    move = (gap > step) ? step : gap;
    if (step == '0) begin
      res = t_x;
    end else if (t_x > d_x) begin
      res = d_x + move;
    end else begin
      res = d_x - move;
    end
    slew_c = WIDTH'(res);
  end

endmodule

// File: rtl/pid_pwm_actuator.sv
// PWM actuator stage behind the PID controller. Duty is sampled only at period
// boundaries; an enable FSM starts/stops cleanly on those boundaries.
// Optional build macro PID_PWM_SLEW_EN adds per-period duty slew limiting.
module pid_pwm_actuator
  import pid_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] control_signal,
  input  logic             enable,
  output logic             pwm_out,
  output logic [WIDTH-1:0] duty,
  output logic             period_start,
  output logic             active
);

  localparam int unsigned     PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] PCNT_LAST = WIDTH'(pwm_period(WIDTH) - 1);

  state_t           state;
  state_t           state_n;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_n;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] pcnt_n;
  logic [WIDTH-1:0] duty_n;
  logic [WIDTH-1:0] target_c;
  logic             ps_n;
  logic             pwm_n;
  logic             active_n;
  logic             ptick_c;
  logic             bnd_c;

`ifdef PID_PWM_SLEW_EN
  localparam int unsigned     STEP_W      = WIDTH + 1;
  localparam logic [STEP_W-1:0] SLEW_STEP_V = STEP_W'(SLEW_STEP);

  // duty is always 0 in IDLE, so feeding duty directly gives slew(0,t) at start.
  pid_pwm_slew #(
    .WIDTH (WIDTH)
  ) u_slew (
    .d      (duty),
    .t      (control_signal),
    .step   (SLEW_STEP_V),
    .slew_c (target_c)
  );
`else
  logic slew_step_unused;

  // Without slew limiting the applied duty loads the control word directly.
  assign target_c         = control_signal;
  assign slew_step_unused = (SLEW_STEP != 0);
`endif

  // Next-state, counter and output computation.
  always_comb begin
    state_n = state;
    pre_n   = pre;
    pcnt_n  = pcnt;
    duty_n  = duty;
    ps_n    = 1'b0;
    ptick_c = (pre == PRE_LAST);
    bnd_c   = ptick_c && (pcnt == PCNT_LAST);

    if (state != IDLE) begin
      pre_n = ptick_c ? '0 : pre + 1'b1;
      if (ptick_c) begin
        pcnt_n = pcnt + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        pre_n  = '0;
        pcnt_n = '0;
        if (enable) begin
          state_n = RUN;
          duty_n  = target_c;
          ps_n    = 1'b1;
        end
      end
      RUN: begin
        if (bnd_c) begin
          pcnt_n = '0;
          duty_n = target_c;
          ps_n   = 1'b1;
        end
        if (!enable) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (bnd_c) begin
          pcnt_n = '0;
          if (enable) begin
            state_n = RUN;
            duty_n  = target_c;
            ps_n    = 1'b1;
          end else begin
            state_n = IDLE;
            pre_n   = '0;
            duty_n  = '0;
          end
        end else if (enable) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        pre_n   = '0;
        pcnt_n  = '0;
        duty_n  = '0;
      end
    endcase

    active_n = (state_n != IDLE);
    pwm_n    = active_n && (pcnt_n < duty_n);
  end

  // State and output registers; pwm_out tracks (state!=IDLE && pcnt<duty) of the same registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pre          <= '0;
      pcnt         <= '0;
      duty         <= '0;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
      active       <= 1'b0;
    end else begin
      state        <= state_n;
      pre          <= pre_n;
      pcnt         <= pcnt_n;
      duty         <= duty_n;
      period_start <= ps_n;
      pwm_out      <= pwm_n;
      active       <= active_n;
    end
  end

endmodule
